mem_wb_writeback: RTL and testbench
===================================

Name: mem_wb_writeback

Overview:
Writeback-stage consumer of the MEM/WB pipeline register outputs. It selects the register-file write data from the memory load, the ALU result or HI/LO, and owns the architectural HI/LO registers. Register-file writes pass through a small retire queue with a ready handshake toward the register file. It also keeps a retired-instruction counter.

Parameters:
DEPTH, 2, retire-queue entries (power of two, 2..8)
CNT_W, 32, retire counter width

Ports:
Clock  input  1  single clock, rising edge
Reset  input  1  synchronous, active-low reset
in_valid  input  1  MEM/WB outputs carry a valid instruction this cycle
in_ready  output  1  writeback can accept; upstream holds all inputs while low
RegWrite_in  input  1  instruction writes the register file
MemtoReg_in  input  1  1 = write DataMemory_in; 0 = write ALUResult_in
DataMemory_in  input  32  load data
ALUResult_in  input  32  ALU result
destinationReg_in  input  5  destination register
Hi_in  input  32  new HI value
Lo_in  input  32  new LO value
WriteEnable_in  input  1  update HI/LO (mult/div/mthi/mtlo)
ReadEnable_in  input  1  write data comes from HI/LO (mfhi/mflo); overrides MemtoReg_in
HiLoSel_in  input  1  0 = LO, 1 = HI (used when ReadEnable_in = 1)
rf_we  output  1  register-file write request (queue head valid)
rf_waddr  output  5  write address of the queue head
rf_wdata  output  32  write data of the queue head
rf_ready  input  1  register file consumes the head this cycle
hi_q  output  32  architectural HI
lo_q  output  32  architectural LO
retire_count  output  CNT_W  count of accepted instructions
fwd_src_reg  input  5  forwarding lookup address (WB_FWD_EN only)
fwd_hit  output  1  a queued entry matches fwd_src_reg
fwd_data  output  32  data of the youngest matching entry

Behaviour:
- Accept = in_valid & in_ready. in_ready = !full. No combinational path from rf_ready to in_ready.
- Write-data select at accept, in priority order:
  - ReadEnable_in = 1: HiLoSel_in ? hi_q : lo_q, using the current (pre-update) values.
  - otherwise MemtoReg_in ? DataMemory_in : ALUResult_in.
- Enqueue on accept only when RegWrite_in = 1 and destinationReg_in != 0. Writes to $0 are dropped silently but still retire.
- HI/LO update: on accept with WriteEnable_in = 1, hi_q <= Hi_in and lo_q <= Lo_in next edge.
  - If ReadEnable_in and WriteEnable_in are both set on the same instruction, the read sees the old values (read-before-write).
- retire_count increments by 1 on every accept, whether or not the instruction enqueues. Wraps modulo 2^CNT_W.
- Queue:
  - FIFO with DEPTH entries; head drives rf_we/rf_waddr/rf_wdata from registers.
  - Pop when rf_we & rf_ready.
  - Latency: accept in cycle N -> earliest rf_we in cycle N+1.
- Full/empty boundaries:
  - Push and pop in the same cycle while not full: occupancy unchanged, order preserved.
  - When full, in_ready = 0 even if a pop occurs that cycle; the slot frees next cycle.
  - When empty, rf_we = 0 and rf_waddr/rf_wdata hold their last value (don't-care).
  - Pointers wrap modulo DEPTH.
- Reset (Reset = 0 at a rising edge):
  - Queue emptied; rf_we = 0, rf_waddr = 0, rf_wdata = 0.
  - hi_q = 0, lo_q = 0, retire_count = 0, fwd_hit = 0, fwd_data = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
  - Reset mid-operation discards queued writes, and any accept in the reset cycle is ignored.
- No state machine beyond the FIFO occupancy state (EMPTY / PARTIAL / FULL), derived from the count.

Optional Feature:
WB_FWD_EN
- Defined: combinational lookup over valid queue entries. fwd_hit = 1 if any entry's waddr == fwd_src_reg and fwd_src_reg != 0. fwd_data = wdata of the youngest match.
- Not defined: fwd_hit = 0 and fwd_data = 0 constant, no lookup logic. Hazard logic must then stall while rf_we = 1.

Decomposition:
- Package wb_pkg holds:
  - DEPTH_DEFAULT and CNT_W_DEFAULT.
  - REG_ZERO = 5'd0.
  - HILO_SEL_LO = 0, HILO_SEL_HI = 1.
  - Entry struct {waddr[4:0], wdata[31:0]}.
- One sub-module: wb_retire_fifo, a parameterised FIFO with push/pop and per-entry visibility for the forwarding search. The data select, HI/LO registers and counter stay in the top level.

Test Plan:
- Reset, then load: in_valid = 1, RegWrite = 1, MemtoReg = 1, DataMemory = 0xDEADBEEF, dest = 8, rf_ready = 1 -> next cycle rf_we = 1, waddr = 8, wdata = 0xDEADBEEF; retire_count = 1.
- $0 write: dest = 0, RegWrite = 1 -> rf_we never asserts; retire_count increments.
- HI/LO: mult with Hi_in = 0x1, Lo_in = 0x2, WriteEnable = 1; then mfhi (ReadEnable = 1, HiLoSel = 1, dest = 9) -> wdata = 0x1. Same-instruction read and write with old LO = 0x2, new Lo_in = 0x7 -> wdata = 0x2, lo_q = 0x7.
- Backpressure: rf_ready = 0, three ALU writes offered -> two accepted, in_ready = 0. Raise rf_ready -> writes drain in order, third accepted one cycle after the first pop.
- Reset mid-operation: queue holds 2 entries, Reset = 0 for one cycle -> rf_we = 0, hi_q = lo_q = 0, retire_count = 0; queued writes never appear.
- WB_FWD_EN: queue holds r5 = 0x10 (older) and r5 = 0x20 (newer); fwd_src_reg = 5 -> fwd_hit = 1, fwd_data = 0x20. fwd_src_reg = 0 -> fwd_hit = 0.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the MEM/WB writeback slice
package wb_pkg;

   localparam int DEPTH_DEFAULT = 2;
   localparam int CNT_W_DEFAULT = 32;

   localparam logic [4:0] REG_ZERO    = 5'd0;
   localparam logic       HILO_SEL_LO = 1'b0;
   localparam logic       HILO_SEL_HI = 1'b1;

   // One pending register-file write
   typedef struct packed {
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } wb_entry_t;

   // Retire-queue occupancy, derived purely from the entry count
   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_state_e;

endpackage

// File: rtl/wb_retire_fifo.sv
// rtl/wb_retire_fifo.sv - retire queue of pending register-file writes, entries exposed oldest-first
module wb_retire_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  push_i,
   input  wb_entry_t             push_data_i,
   input  logic                  pop_i,
   output wb_entry_t             head_o,
   output logic                  head_valid_o,
   output logic                  full_o,
   output wb_entry_t [DEPTH-1:0] entries_o,
   output logic [DEPTH-1:0]      entry_valid_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   wb_entry_t         mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q;
   logic [PW-1:0]     rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic [CW-1:0]     count_d;
   occ_state_e        occ;
   logic              push_eff;
   logic              pop_eff;

   // Occupancy classification and guarded push/pop
   always_comb begin
      occ = OCC_PARTIAL;
      if (count_q == '0)
         occ = OCC_EMPTY;
      else if (count_q == CW'(DEPTH))
         occ = OCC_FULL;
      push_eff = push_i && (occ != OCC_FULL);
      pop_eff  = pop_i && (occ != OCC_EMPTY);
      count_d  = count_q;
      case ({push_eff, pop_eff})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage, pointers and count; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_eff) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (pop_eff)
            rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
      end
   end

   // Age-ordered view of the queue: index 0 is the oldest entry
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         entries_o[k]     = mem_q[rd_ptr_q + PW'(k)];
         entry_valid_o[k] = (CW'(k) < count_q);
      end
   end

   assign head_o       = mem_q[rd_ptr_q];
   assign head_valid_o = (occ != OCC_EMPTY);
   assign full_o       = (occ == OCC_FULL);

endmodule

// File: rtl/mem_wb_writeback.sv
// rtl/mem_wb_writeback.sv - writeback stage: data select, HI/LO, retire queue, retire counter; forwarding lookup under WB_FWD_EN
module mem_wb_writeback
   import wb_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             RegWrite_in,
   input  logic             MemtoReg_in,
   input  logic [31:0]      DataMemory_in,
   input  logic [31:0]      ALUResult_in,
   input  logic [4:0]       destinationReg_in,
   input  logic [31:0]      Hi_in,
   input  logic [31:0]      Lo_in,
   input  logic             WriteEnable_in,
   input  logic             ReadEnable_in,
   input  logic             HiLoSel_in,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [31:0]      rf_wdata,
   input  logic             rf_ready,
   output logic [31:0]      hi_q,
   output logic [31:0]      lo_q,
   output logic [CNT_W-1:0] retire_count,
   input  logic [4:0]       fwd_src_reg,
   output logic             fwd_hit,
   output logic [31:0]      fwd_data
);

   logic                  accept;
   logic                  push;
   logic                  full;
   logic [31:0]           hilo_rd;
   wb_entry_t             new_entry;
   wb_entry_t             head;
   wb_entry_t [DEPTH-1:0] entries;
   logic [DEPTH-1:0]      entry_valid;
   logic [31:0]           hi_d;
   logic [31:0]           lo_d;
   logic [CNT_W-1:0]      retire_count_q;
   logic [CNT_W-1:0]      retire_count_d;

   // in_ready depends only on registered occupancy, never on rf_ready
   assign in_ready = !full;
   assign accept   = in_valid && in_ready;

   // Write-data select; mfhi/mflo read the pre-update HI/LO values
   always_comb begin
      hilo_rd           = (HiLoSel_in == HILO_SEL_HI) ? hi_q : lo_q;
      new_entry.waddr   = destinationReg_in;
      new_entry.wdata   = MemtoReg_in ? DataMemory_in : ALUResult_in;
      if (ReadEnable_in)
         new_entry.wdata = hilo_rd;
      push = accept && RegWrite_in && (destinationReg_in != REG_ZERO);
   end

   // Next-state for HI/LO and the retire counter
   always_comb begin
      hi_d           = hi_q;
      lo_d           = lo_q;
      retire_count_d = retire_count_q;
      if (accept) begin
         retire_count_d = retire_count_q + CNT_W'(1);
         if (WriteEnable_in) begin
            hi_d = Hi_in;
            lo_d = Lo_in;
         end
      end
   end

   // Architectural HI/LO and retire counter registers
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         hi_q           <= '0;
         lo_q           <= '0;
         retire_count_q <= '0;
      end else begin
         hi_q           <= hi_d;
         lo_q           <= lo_d;
         retire_count_q <= retire_count_d;
      end
   end

   assign retire_count = retire_count_q;

   wb_retire_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i         (Clock),
      .rstn_i        (Reset),
      .push_i        (push),
      .push_data_i   (new_entry),
      .pop_i         (rf_ready),
      .head_o        (head),
      .head_valid_o  (rf_we),
      .full_o        (full),
      .entries_o     (entries),
      .entry_valid_o (entry_valid)
   );

   assign rf_waddr = head.waddr;
   assign rf_wdata = head.wdata;

`ifdef WB_FWD_EN
   // Forwarding search oldest-to-youngest so the youngest match wins
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (entry_valid[k] && (entries[k].waddr == fwd_src_reg) &&
             (fwd_src_reg != REG_ZERO)) begin
            fwd_hit  = 1'b1;
            fwd_data = entries[k].wdata;
         end
      end
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{fwd_src_reg, entries, entry_valid};
   assign fwd_hit    = 1'b0;
   assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb/tb_mem_wb_writeback.sv - directed self-checking bench for mem_wb_writeback
module tb_mem_wb_writeback;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        in_valid;
   logic        in_ready;
   logic        RegWrite_in;
   logic        MemtoReg_in;
   logic [31:0] DataMemory_in;
   logic [31:0] ALUResult_in;
   logic [4:0]  destinationReg_in;
   logic [31:0] Hi_in;
   logic [31:0] Lo_in;
   logic        WriteEnable_in;
   logic        ReadEnable_in;
   logic        HiLoSel_in;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        rf_ready;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [31:0] retire_count;
   logic [4:0]  fwd_src_reg;
   logic        fwd_hit;
   logic [31:0] fwd_data;

   int n_chk  = 0;
   int n_fail = 0;

   mem_wb_writeback #(.DEPTH(2), .CNT_W(32)) dut (
      .Clock             (Clock),
      .Reset             (Reset),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .RegWrite_in       (RegWrite_in),
      .MemtoReg_in       (MemtoReg_in),
      .DataMemory_in     (DataMemory_in),
      .ALUResult_in      (ALUResult_in),
      .destinationReg_in (destinationReg_in),
      .Hi_in             (Hi_in),
      .Lo_in             (Lo_in),
      .WriteEnable_in    (WriteEnable_in),
      .ReadEnable_in     (ReadEnable_in),
      .HiLoSel_in        (HiLoSel_in),
      .rf_we             (rf_we),
      .rf_waddr          (rf_waddr),
      .rf_wdata          (rf_wdata),
      .rf_ready          (rf_ready),
      .hi_q              (hi_q),
      .lo_q              (lo_q),
      .retire_count      (retire_count),
      .fwd_src_reg       (fwd_src_reg),
      .fwd_hit           (fwd_hit),
      .fwd_data          (fwd_data)
   );

   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic drive(input logic v, input logic rw, input logic m2r,
                        input logic [31:0] dm, input logic [31:0] alu,
                        input logic [4:0] dst, input logic [31:0] hi,
                        input logic [31:0] lo, input logic we,
                        input logic re, input logic sel);
      in_valid          = v;
      RegWrite_in       = rw;
      MemtoReg_in       = m2r;
      DataMemory_in     = dm;
      ALUResult_in      = alu;
      destinationReg_in = dst;
      Hi_in             = hi;
      Lo_in             = lo;
      WriteEnable_in    = we;
      ReadEnable_in     = re;
      HiLoSel_in        = sel;
   endtask

   task automatic idle();
      drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 0, 0, 0);
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      rf_ready = 1'b0;
      fwd_src_reg = 5'd0;
      idle();
      repeat (2) @(negedge Clock);
      n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %0h exp 0", rf_we); end
      n_chk++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0h exp 0", rf_waddr); end
      n_chk++; if (rf_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %0h exp 0", rf_wdata); end
      n_chk++; if (hi_q !== 32'h0 || lo_q !== 32'h0) begin n_fail++; $display("FAIL reset_hilo: got %0h/%0h exp 0/0", hi_q, lo_q); end
      n_chk++; if (retire_count !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %0h exp 0", retire_count); end
      n_chk++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin n_fail++; $display("FAIL reset_fwd: got %0h/%0h exp 0/0", fwd_hit, fwd_data); end
      Reset = 1'b1;
      @(negedge Clock);
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0h exp 1", in_ready); end
   endtask

   task automatic test_load();
      rf_ready = 1'b1;
      drive(1, 1, 1, 32'hDEADBEEF, 32'h1234, 5'd8, 32'h0, 32'h0, 0, 0, 0);
      @(negedge Clock);
      n_chk++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL load_rf_we: got %0h exp 1", rf_we); end
      n_chk++; if (rf_waddr !== 5'd8) begin n_fail++; $display("FAIL load_waddr: got %0d exp 8", rf_waddr); end
      n_chk++; if (rf_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_wdata: got %0h exp deadbeef", rf_wdata); end
      n_chk++; if (retire_count !== 32'd1) begin n_fail++; $display("FAIL load_count: got %0d exp 1", retire_count); end
      idle();
      @(negedge Clock);
      n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL load_drained: got %0h exp 0", rf_we); end
   endtask

   task automatic test_zero_dest();
      drive(1, 1, 0, 32'h0, 32'h5555, 5'd0, 32'h0, 32'h0, 0, 0, 0);
      @(negedge Clock);
      n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL zero_rf_we: got %0h exp 0", rf_we); end
      n_chk++; if (retire_count !== 32'd2) begin n_fail++; $display("FAIL zero_count: got %0d exp 2", retire_count); end
      idle();
      @(negedge Clock);
      n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL zero_rf_we_later: got %0h exp 0", rf_we); end
   endtask

   task automatic test_hilo();
      drive(1, 0, 0, 32'h0, 32'h0, 5'd0, 32'h1, 32'h2, 1, 0, 0);
      @(negedge Clock);
      n_chk++; if (hi_q !== 32'h1 || lo_q !== 32'h2) begin n_fail++; $display("FAIL mult_hilo: got %0h/%0h exp 1/2", hi_q, lo_q); end
      n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mult_rf_we: got %0h exp 0", rf_we); end
      drive(1, 1, 0, 32'h0, 32'hAAAA, 5'd9, 32'h0, 32'h0, 0, 1, 1);
      @(negedge Clock);
      n_chk++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin n_fail++; $display("FAIL mfhi_head: got we=%0h addr=%0d exp we=1 addr=9", rf_we, rf_waddr); end
      n_chk++; if (rf_wdata !== 32'h1) begin n_fail++; $display("FAIL mfhi_wdata: got %0h exp 1", rf_wdata); end
      drive(1, 1, 1, 32'hBAD, 32'hBBBB, 5'd10, 32'h1, 32'h7, 1, 1, 0);
      @(negedge Clock);
      n_chk++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10) begin n_fail++; $display("FAIL rbw_head: got we=%0h addr=%0d exp we=1 addr=10", rf_we, rf_waddr); end
      n_chk++; if (rf_wdata !== 32'h2) begin n_fail++; $display("FAIL rbw_wdata: got %0h exp 2", rf_wdata); end
      n_chk++; if (lo_q !== 32'h7 || hi_q !== 32'h1) begin n_fail++; $display("FAIL rbw_hilo: got %0h/%0h exp 1/7", hi_q, lo_q); end
      n_chk++; if (retire_count !== 32'd5) begin n_fail++; $display("FAIL hilo_count: got %0d exp 5", retire_count); end
      idle();
      @(negedge Clock);
      n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL hilo_drained: got %0h exp 0", rf_we); end
   endtask

   task automatic test_backpressure();
      rf_ready = 1'b0;
      drive(1, 1, 0, 32'h0, 32'h111, 5'd11, 32'h0, 32'h0, 0, 0, 0);
      @(negedge Clock);
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one: got %0h exp 1", in_ready); end
      drive(1, 1, 0, 32'h0, 32'h222, 5'd12, 32'h0, 32'h0, 0, 0, 0);
      @(negedge Clock);
      drive(1, 1, 0, 32'h0, 32'h333, 5'd13, 32'h0, 32'h0, 0, 0, 0);
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %0h exp 0", in_ready); end
      n_chk++; if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'h111) begin n_fail++; $display("FAIL bp_head0: got we=%0h addr=%0d data=%0h exp 1/11/111", rf_we, rf_waddr, rf_wdata); end
      @(negedge Clock);
      n_chk++; if (retire_count !== 32'd7 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got cnt=%0d rdy=%0h exp 7/0", retire_count, in_ready); end
      rf_ready = 1'b1;
      @(negedge Clock);
      n_chk++; if (rf_waddr !== 5'd12 || rf_wdata !== 32'h222 || rf_we !== 1'b1) begin n_fail++; $display("FAIL bp_head1: got we=%0h addr=%0d data=%0h exp 1/12/222", rf_we, rf_waddr, rf_wdata); end
      n_chk++; if (in_ready !== 1'b1 || retire_count !== 32'd7) begin n_fail++; $display("FAIL bp_slot_free: got rdy=%0h cnt=%0d exp 1/7", in_ready, retire_count); end
      @(negedge Clock);
      idle();
      n_chk++; if (rf_waddr !== 5'd13 || rf_wdata !== 32'h333 || rf_we !== 1'b1) begin n_fail++; $display("FAIL bp_head2: got we=%0h addr=%0d data=%0h exp 1/13/333", rf_we, rf_waddr, rf_wdata); end
      n_chk++; if (retire_count !== 32'd8) begin n_fail++; $display("FAIL bp_count: got %0d exp 8", retire_count); end
      @(negedge Clock);
      n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %0h exp 0", rf_we); end
   endtask

   task automatic test_reset_mid();
      rf_ready = 1'b0;
      drive(1, 1, 0, 32'h0, 32'hA1, 5'd14, 32'hAA, 32'hBB, 1, 0, 0);
      @(negedge Clock);
      drive(1, 1, 0, 32'h0, 32'hA2, 5'd15, 32'hAA, 32'hBB, 1, 0, 0);
      @(negedge Clock);
      n_chk++; if (in_ready !== 1'b0 || hi_q !== 32'hAA) begin n_fail++; $display("FAIL mid_prefill: got rdy=%0h hi=%0h exp 0/aa", in_ready, hi_q); end
      Reset = 1'b0;
      rf_ready = 1'b1;
      drive(1, 1, 0, 32'h0, 32'hA3, 5'd16, 32'hCC, 32'hDD, 1, 0, 0);
      @(negedge Clock);
      Reset = 1'b1;
      idle();
      n_chk++; if (rf_we !== 1'b0 || retire_count !== 32'd0) begin n_fail++; $display("FAIL mid_cleared: got we=%0h cnt=%0d exp 0/0", rf_we, retire_count); end
      n_chk++; if (hi_q !== 32'h0 || lo_q !== 32'h0) begin n_fail++; $display("FAIL mid_hilo: got %0h/%0h exp 0/0", hi_q, lo_q); end
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_ghost_write: cycle %0d got we=%0h addr=%0d exp 0", i, rf_we, rf_waddr); end
      end
      rf_ready = 1'b0;
      drive(1, 1, 0, 32'h0, 32'hC1, 5'd17, 32'h0, 32'h0, 0, 0, 0);
      @(negedge Clock);
      Reset = 1'b0;
      drive(1, 1, 0, 32'h0, 32'hC2, 5'd18, 32'h55, 32'h66, 1, 0, 0);
      @(negedge Clock);
      Reset = 1'b1;
      idle();
      n_chk++; if (retire_count !== 32'd0 || rf_we !== 1'b0 || hi_q !== 32'h0) begin n_fail++; $display("FAIL reset_cycle_accept: got cnt=%0d we=%0h hi=%0h exp 0/0/0", retire_count, rf_we, hi_q); end
      @(negedge Clock);
      n_chk++; if (rf_we !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cycle_after: got we=%0h rdy=%0h exp 0/1", rf_we, in_ready); end
   endtask

   task automatic test_fwd();
      rf_ready = 1'b0;
      drive(1, 1, 0, 32'h0, 32'h10, 5'd5, 32'h0, 32'h0, 0, 0, 0);
      @(negedge Clock);
      drive(1, 1, 0, 32'h0, 32'h20, 5'd5, 32'h0, 32'h0, 0, 0, 0);
      @(negedge Clock);
      idle();
      fwd_src_reg = 5'd5;
      #1;
      n_chk++; if (rf_wdata !== 32'h10) begin n_fail++; $display("FAIL fwd_head_oldest: got %0h exp 10", rf_wdata); end
`ifdef WB_FWD_EN
      n_chk++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h20) begin n_fail++; $display("FAIL fwd_youngest: got hit=%0h data=%0h exp 1/20", fwd_hit, fwd_data); end
      fwd_src_reg = 5'd0;
      #1;
      n_chk++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_reg0: got %0h exp 0", fwd_hit); end
      fwd_src_reg = 5'd6;
      #1;
      n_chk++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_nomatch: got %0h exp 0", fwd_hit); end
`else
      n_chk++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin n_fail++; $display("FAIL fwd_disabled: got hit=%0h data=%0h exp 0/0", fwd_hit, fwd_data); end
`endif
      rf_ready = 1'b1;
      fwd_src_reg = 5'd0;
      repeat (3) @(negedge Clock);
      n_chk++; if (rf_we !== 1'b0 || retire_count !== 32'd2) begin n_fail++; $display("FAIL fwd_drain: got we=%0h cnt=%0d exp 0/2", rf_we, retire_count); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_zero_dest();
      test_hilo();
      test_backpressure();
      test_reset_mid();
      test_fwd();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
